div_src_arbiter: RTL

- Arbitrates the three serial receive paths (UART, I2C, SPI) that can each deliver a new clock-divider byte, and sequences loading that byte into the clock divider.
- Buffers one byte per source and picks a winner by fixed-priority, round-robin or single-source policy.
- Issues a one-cycle load strobe with the divisor, then enforces a hold-off window so the divider output is not retuned back-to-back.
- Sits between the receivers and the clock divider; mode and status connect to the register block.

---
 rtl/div_src_arbiter_pkg.sv | 56 +++++
 rtl/div_src_arbiter_slot.sv | 62 ++++++
 rtl/div_src_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_src_arbiter_pkg.sv
// Shared definitions for the clock-divider source arbiter.
//   - Source index constants (UART/I2C/SPI/none)
//   - Arbitration mode encodings
//   - FSM state enum
//   - Helpers: next round-robin source, one-hot decode, rotating priority pick
package div_src_arbiter_pkg;

    localparam logic [1:0] SRC_UART = 2'd0;
    localparam logic [1:0] SRC_I2C  = 2'd1;
    localparam logic [1:0] SRC_SPI  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_SEL   = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;  // behaves as MODE_FIXED

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // (k+1) mod 3 over the three real sources.
    function automatic logic [1:0] next_src(input logic [1:0] k);
        return (k == SRC_SPI) ? SRC_UART : k + 2'd1;
    endfunction

    function automatic logic [2:0] src_onehot(input logic [1:0] k);
        logic [2:0] v;
        v = 3'b000;
        case (k)
            SRC_UART: v = 3'b001;
            SRC_I2C:  v = 3'b010;
            SRC_SPI:  v = 3'b100;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

    // First requesting source found when searching upward (mod 3) from
    // 'start'. Iterating from the far end lets the nearest hit win last.
    function automatic logic [1:0] pick_src(input logic [2:0] req, input logic [1:0] start);
        logic [1:0] win;
        int         idx;
        win = SRC_NONE;
        for (int i = 2; i >= 0; i--) begin
            idx = (int'(start) + i) % 3;
            if (req[idx]) begin
                win = 2'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/div_src_arbiter_slot.sv
// div_src_slot: one-byte buffer for a single receive source.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   rdone_i       : byte strobe, rdata_i valid in the same cycle
//   grant_i       : arbiter consumed this slot this cycle (clears pend)
//   clr_flags_i   : clears the sticky overrun flag
//   pend_o        : a byte is waiting
//   ovr_o         : sticky, a waiting byte was overwritten before use
//   data_o        : buffered byte (newest wins)
module div_src_slot (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rdone_i,
    input  logic [7:0] rdata_i,
    input  logic       grant_i,
    input  logic       clr_flags_i,
    output logic       pend_o,
    output logic       ovr_o,
    output logic [7:0] data_o
);

    logic       pend_q, pend_d;
    logic       ovr_q, ovr_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        data_d = data_q;
        if (grant_i) begin
            pend_d = 1'b0;
        end
        if (clr_flags_i) begin
            ovr_d = 1'b0;
        end
        // A new byte overrides both the grant clear and the flag clear.
        // Overrun only when the old byte is lost, i.e. not granted now.
        if (rdone_i) begin
            data_d = rdata_i;
            pend_d = 1'b1;
            if (pend_q && !grant_i) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            data_q <= data_d;
        end
    end

    assign pend_o = pend_q;
    assign ovr_o  = ovr_q;
    assign data_o = data_q;

endmodule

// File: rtl/div_src_arbiter.sv
// div_src_arbiter: picks one of three buffered divisor bytes (UART, I2C,
// SPI) and sequences a single-cycle load into the clock divider, followed
// by a hold-off window.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   arb_en_i            : grants allowed when high
//   arb_mode_i          : 00 fixed, 01 round-robin, 10 single source, 11 = 00
//   src_sel_i           : source for mode 10 (3 = none)
//   *_rdata_i/*_rdone_i : per-source byte and strobe
//   clr_flags_i         : clears ovr_o and zero_err_o
//   div_data_o          : divisor, held between loads
//   div_load_o          : one-cycle load strobe
//   grant_src_o         : source of last load (3 = none since reset)
//   busy_o              : high in LOAD and HOLD
//   pend_o, ovr_o       : per-source pending / sticky overrun
//   zero_err_o          : sticky, a zero divisor was dropped
//   dbg_state_o         : current FSM state
//
// Handshake: each rdone is a fire-and-forget strobe (no ready); the slot
// always accepts. div_load_o is a fire-and-forget strobe toward the divider.
module div_src_arbiter
    import div_src_arbiter_pkg::*;
#(
    parameter int HOLD_CYC    = 16,
    parameter bit REJECT_ZERO = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arb_en_i,
    input  logic [1:0] arb_mode_i,
    input  logic [1:0] src_sel_i,
    input  logic [7:0] uart_rdata_i,
    input  logic       uart_rdone_i,
    input  logic [7:0] i2c_rdata_i,
    input  logic       i2c_rdone_i,
    input  logic [7:0] spi_rdata_i,
    input  logic       spi_rdone_i,
    input  logic       clr_flags_i,
    output logic [7:0] div_data_o,
    output logic       div_load_o,
    output logic [1:0] grant_src_o,
    output logic       busy_o,
    output logic [2:0] pend_o,
    output logic [2:0] ovr_o,
    output logic       zero_err_o,
    output logic [1:0] dbg_state_o
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    // ---------------- source slots ----------------
    logic [2:0] rdone_vec;
    logic [2:0] grant_vec;
    logic [2:0] pend_vec;
    logic [2:0] ovr_vec;
    logic [7:0] rdata_arr [3];
    logic [7:0] slot_data [3];

    assign rdone_vec    = {spi_rdone_i, i2c_rdone_i, uart_rdone_i};
    assign rdata_arr[0] = uart_rdata_i;
    assign rdata_arr[1] = i2c_rdata_i;
    assign rdata_arr[2] = spi_rdata_i;

    for (genvar g = 0; g < 3; g++) begin : g_slot
        div_src_slot u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .rdone_i     (rdone_vec[g]),
            .rdata_i     (rdata_arr[g]),
            .grant_i     (grant_vec[g]),
            .clr_flags_i (clr_flags_i),
            .pend_o      (pend_vec[g]),
            .ovr_o       (ovr_vec[g]),
            .data_o      (slot_data[g])
        );
    end

    // ---------------- state ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]       div_data_q, div_data_d;
    logic             div_load_q, div_load_d;
    logic [1:0]       grant_src_q, grant_src_d;
    logic             zero_err_q, zero_err_d;

    // ---------------- eligibility and winner ----------------
    logic [2:0] elig;
    logic [1:0] search_start;
    logic [1:0] win_src;
    logic [7:0] win_data;

    always_comb begin
        elig = 3'b000;
        case (arb_mode_i)
            MODE_SEL: begin
                case (src_sel_i)
                    SRC_UART: elig[0] = pend_vec[0];
                    SRC_I2C:  elig[1] = pend_vec[1];
                    SRC_SPI:  elig[2] = pend_vec[2];
                    default:  elig    = 3'b000;
                endcase
            end
            default: elig = pend_vec;  // fixed, round-robin, reserved
        endcase

        search_start = (arb_mode_i == MODE_RR) ? rr_ptr_q : SRC_UART;
        win_src      = pick_src(elig, search_start);

        win_data = 8'h00;
        case (win_src)
            SRC_UART: win_data = slot_data[0];
            SRC_I2C:  win_data = slot_data[1];
            SRC_SPI:  win_data = slot_data[2];
            default:  win_data = 8'h00;
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        div_data_d  = div_data_q;
        div_load_d  = 1'b0;
        grant_src_d = grant_src_q;
        zero_err_d  = zero_err_q;
        grant_vec   = 3'b000;

        if (clr_flags_i) begin
            zero_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Mode and enable only matter here; LOAD/HOLD ignore them.
                if (arb_en_i && (win_src != SRC_NONE)) begin
                    grant_vec = src_onehot(win_src);
                    rr_ptr_d  = next_src(win_src);
                    if (REJECT_ZERO && (win_data == 8'h00)) begin
                        // Dropped byte still consumes its turn.
                        zero_err_d = 1'b1;
                    end else begin
                        div_data_d  = win_data;
                        grant_src_d = win_src;
                        div_load_d  = 1'b1;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = (HOLD_CYC > 0) ? HOLD : IDLE;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= SRC_UART;
            div_data_q  <= 8'h00;
            div_load_q  <= 1'b0;
            grant_src_q <= SRC_NONE;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            div_data_q  <= div_data_d;
            div_load_q  <= div_load_d;
            grant_src_q <= grant_src_d;
            zero_err_q  <= zero_err_d;
        end
    end

    // ---------------- outputs ----------------
    assign div_data_o  = div_data_q;
    assign div_load_o  = div_load_q;
    assign grant_src_o = grant_src_q;
    assign busy_o      = (state_q != IDLE);
    assign pend_o      = pend_vec;
    assign ovr_o       = ovr_vec;
    assign zero_err_o  = zero_err_q;
    assign dbg_state_o = state_q;

endmodule
